bcd_stopwatch: RTL and testbench
================================

Name: bcd_stopwatch

Overview:
- Four-digit BCD mm:ss stopwatch core. Sits directly downstream of the FreqDivisor output (slow square wave) and upstream of four 7-segment decoders (HEX0..HEX3).
- Replaces the single Cont_M10 digit with a cascaded 00:00–59:59 counter.
- Adds start/pause, clear and lap-freeze control from board push-buttons.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of each input synchronizer (minimum 2).
- DEBOUNCE_CYCLES, 1000000, lockout after an accepted press (20 ms at 50 MHz); counter width $clog2(DEBOUNCE_CYCLES+1).
- KEY_ACTIVE_LOW, 1, 1 = buttons read 0 when pressed (DE2 KEY), 0 = active-high.

Ports:
- clk  in  1  system clock (CLOCK_50 at top level)
- rst  in  1  asynchronous, active-high reset
- tick_in  in  1  divided-clock square wave from FreqDivisor; each rising edge = one second
- key_start  in  1  start/pause button, polarity per KEY_ACTIVE_LOW
- key_clear  in  1  clear button
- key_lap  in  1  lap-freeze button
- sec_ones  out  4  displayed seconds units, BCD 0-9
- sec_tens  out  4  displayed seconds tens, BCD 0-5
- min_ones  out  4  displayed minutes units, BCD 0-9
- min_tens  out  4  displayed minutes tens, BCD 0-5
- running  out  1  high in RUN state
- lap_active  out  1  high while display is frozen
- wrap  out  1  one-cycle pulse on 59:59 -> 00:00

Behaviour:
- Reset (async, rst=1):
  - all internal counts, snapshot and digit outputs = 0
  - state IDLE; running=0, lap_active=0, wrap=0
  - synchronizers and edge registers cleared; debounce counters = 0
  - tick edge register cleared to 0, so tick_in held high at release produces one edge after SYNC_STAGES cycles (accepted behaviour).
- Input conditioning:
  - each of the 4 inputs passes through a SYNC_STAGES synchronizer; buttons are normalised to active-high.
  - tick event = synced rising edge, 1-cycle pulse; latency from tick_in edge to count update = SYNC_STAGES+1 clk.
  - button press event = synced rising edge (after normalisation), only if that button's lockout counter is 0.
  - an accepted press loads its lockout counter with DEBOUNCE_CYCLES, which counts down to 0; edges during lockout are ignored.
  - press latency = SYNC_STAGES+1 clk.
- FSM states and transitions:
  - IDLE: start -> RUN.
  - RUN: start -> PAUSE.
  - PAUSE: start -> RUN.
  - clear in any state -> IDLE, counts=0, lap_active=0.
- Priority within a cycle: clear > tick > start.
  - RUN with tick+start: tick is counted, then PAUSE.
  - IDLE with tick+start: no count; counting begins on the next tick.
- Counting (RUN only, on tick event):
  - sec_ones increments; at 9 it wraps to 0 and carries into sec_tens.
  - sec_tens wraps at 5 and carries into min_ones; min_ones wraps at 9 and carries into min_tens; min_tens wraps at 5.
  - 59:59 + tick = 00:00 with wrap=1 for exactly that cycle; counting continues.
- Lap:
  - in RUN or PAUSE, a lap press toggles lap_active.
  - rising toggle captures the current count into the snapshot; outputs show the snapshot while lap_active=1.
  - internal count keeps running while frozen; falling toggle returns outputs to live count.
  - lap press in IDLE is ignored.
- Outputs:
  - digit outputs are registered: they equal live count (or snapshot) one clk after update.
  - BCD values never exceed the limits above.
- Reset mid-count or mid-lockout: immediate return to the reset values above.

Decomposition:
- Package stopwatch_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, PAUSE} sw_state_t
  - typedef logic [3:0] bcd_t
  - localparams SEC_TENS_MAX=5, MIN_TENS_MAX=5, UNITS_MAX=9
- Sub-module key_cond: synchronizer + edge detect + lockout, parameterised by SYNC_STAGES, DEBOUNCE_CYCLES and polarity. Instantiated 3 times for buttons.
- The tick uses the sync + edge path only, with no lockout.
- bcd_stopwatch holds the FSM, BCD cascade, snapshot and output registers.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, KEY_ACTIVE_LOW=1):
1. Reset, press start, apply 75 tick edges -> digits 01:15, running=1, wrap=0 throughout.
2. Preload via 3599 ticks in RUN (59:59), one more tick -> 00:00, wrap high exactly 1 clk, 3+1 clk after tick edge.
3. At 00:10 press start, apply 5 ticks, press start, 3 ticks -> PAUSE holds 00:10, then RUN 00:13.
4. At 00:20 press lap, 7 ticks -> outputs 00:20, lap_active=1; press lap -> outputs 00:27, lap_active=0.
5. key_start bounces 0/1/0 within 4 clk -> exactly one state change; clear asserted same cycle as start+tick in RUN -> IDLE, 00:00, lap_active=0.
6. Assert rst mid-count at 12:34 with lap active and lockout running -> all outputs 0 asynchronously; first start press after release is accepted.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types for the mm:ss BCD stopwatch: FSM states, BCD digit type,
// digit limits and a saturating-wrap digit step helper.
// Imported by the key conditioner and the stopwatch top.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } sw_state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t SEC_TENS_MAX = 4'd5;
  localparam bcd_t MIN_TENS_MAX = 4'd5;
  localparam bcd_t UNITS_MAX    = 4'd9;

  // Four displayed digits, most significant first.
  typedef struct packed {
    bcd_t min_tens;
    bcd_t min_ones;
    bcd_t sec_tens;
    bcd_t sec_ones;
  } mmss_t;

  // Advance one digit; anything at or above the limit rolls to zero so an
  // out-of-range value can never persist.
  function automatic bcd_t bcd_step(input bcd_t d, input bcd_t lim);
    return (d >= lim) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/key_cond.sv
// Push-button conditioner: polarity normalise, synchronise, rising-edge detect.
// Press pulse appears SYNC_STAGES+1 clk after the pin edge (one-cycle pulse).
// After an accepted press, further edges are ignored for DEBOUNCE_CYCLES clk.
module key_cond
  import stopwatch_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_key,
  output logic o_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic [CW-1:0]          r_lock;
  logic                   w_norm;
  logic                   w_edge;

  // Normalise before the synchronizer so a cleared chain means "not pressed".
  assign w_norm  = ACTIVE_LOW ? ~i_key : i_key;
  assign w_edge  = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign o_press = w_edge & (r_lock == '0);

  // Synchronizer chain and edge-history register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], w_norm};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  // Lockout: reload on an accepted press, otherwise count down to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lock <= '0;
    end else if (o_press) begin
      r_lock <= CW'(DEBOUNCE_CYCLES);
    end else if (r_lock != '0) begin
      r_lock <= r_lock - CW'(1);
    end
  end

endmodule

// File: rtl/bcd_stopwatch.sv
// mm:ss BCD stopwatch: start/pause FSM, 00:00-59:59 cascade, lap snapshot.
// Count updates SYNC_STAGES+1 clk after a tick/key edge; digits one clk later.
// No backpressure: every conditioned event is consumed in the cycle it occurs.
module bcd_stopwatch
  import stopwatch_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int KEY_ACTIVE_LOW  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       key_start,
  input  logic       key_clear,
  input  logic       key_lap,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       running,
  output logic       lap_active,
  output logic       wrap
);

  logic [SYNC_STAGES-1:0] r_tick_sync;
  logic                   r_tick_prev;
  logic                   w_tick;
  logic                   w_start;
  logic                   w_clear;
  logic                   w_lap;

  sw_state_t r_state, w_state_nxt;
  mmss_t     r_cnt, w_cnt_nxt;
  mmss_t     r_snap, w_snap_nxt;
  logic      r_lap, w_lap_nxt;
  logic      r_wrap_evt, w_wrap_nxt;
  mmss_t     w_inc;
  logic      w_inc_wrap;

  mmss_t     r_disp;
  logic      r_lap_out;
  logic      r_wrap_out;

  // Tick path: synchronizer and edge detect only; the divider output is clean.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick_sync <= '0;
      r_tick_prev <= 1'b0;
    end else begin
      r_tick_sync <= {r_tick_sync[SYNC_STAGES-2:0], tick_in};
      r_tick_prev <= r_tick_sync[SYNC_STAGES-1];
    end
  end

  assign w_tick = r_tick_sync[SYNC_STAGES-1] & ~r_tick_prev;

  key_cond #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .ACTIVE_LOW     (KEY_ACTIVE_LOW != 0)
  ) u_key_start (
    .clk    (clk),
    .rst    (rst),
    .i_key  (key_start),
    .o_press(w_start)
  );

  key_cond #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .ACTIVE_LOW     (KEY_ACTIVE_LOW != 0)
  ) u_key_clear (
    .clk    (clk),
    .rst    (rst),
    .i_key  (key_clear),
    .o_press(w_clear)
  );

  key_cond #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .ACTIVE_LOW     (KEY_ACTIVE_LOW != 0)
  ) u_key_lap (
    .clk    (clk),
    .rst    (rst),
    .i_key  (key_lap),
    .o_press(w_lap)
  );

  // BCD cascade: live count plus one second, with carry ripple and 59:59 wrap flag.
  always_comb begin
    w_inc      = r_cnt;
    w_inc_wrap = 1'b0;
    w_inc.sec_ones = bcd_step(r_cnt.sec_ones, UNITS_MAX);
    if (r_cnt.sec_ones >= UNITS_MAX) begin
      w_inc.sec_tens = bcd_step(r_cnt.sec_tens, SEC_TENS_MAX);
      if (r_cnt.sec_tens >= SEC_TENS_MAX) begin
        w_inc.min_ones = bcd_step(r_cnt.min_ones, UNITS_MAX);
        if (r_cnt.min_ones >= UNITS_MAX) begin
          w_inc.min_tens = bcd_step(r_cnt.min_tens, MIN_TENS_MAX);
          if (r_cnt.min_tens >= MIN_TENS_MAX) begin
            w_inc_wrap = 1'b1;
          end
        end
      end
    end
  end

  // Next state: clear beats tick beats start; a tick in RUN is counted even
  // if start moves us to PAUSE in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_snap_nxt  = r_snap;
    w_lap_nxt   = r_lap;
    w_wrap_nxt  = 1'b0;
    if (w_clear) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
      w_lap_nxt   = 1'b0;
    end else begin
      if (w_tick && (r_state == RUN)) begin
        w_cnt_nxt  = w_inc;
        w_wrap_nxt = w_inc_wrap;
      end
      if (w_start) begin
        case (r_state)
          IDLE:    w_state_nxt = RUN;
          RUN:     w_state_nxt = PAUSE;
          PAUSE:   w_state_nxt = RUN;
          default: w_state_nxt = IDLE;
        endcase
      end
      // Snapshot the pre-tick count when the freeze engages.
      if (w_lap && (r_state != IDLE)) begin
        w_lap_nxt = ~r_lap;
        if (!r_lap) begin
          w_snap_nxt = r_cnt;
        end
      end
    end
  end

  // State, live count, snapshot and lap registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_snap     <= '0;
      r_lap      <= 1'b0;
      r_wrap_evt <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_snap     <= w_snap_nxt;
      r_lap      <= w_lap_nxt;
      r_wrap_evt <= w_wrap_nxt;
    end
  end

  // Output stage: digits, freeze flag and wrap pulse all move together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_disp     <= '0;
      r_lap_out  <= 1'b0;
      r_wrap_out <= 1'b0;
    end else begin
      r_disp     <= r_lap ? r_snap : r_cnt;
      r_lap_out  <= r_lap;
      r_wrap_out <= r_wrap_evt;
    end
  end

  assign sec_ones   = r_disp.sec_ones;
  assign sec_tens   = r_disp.sec_tens;
  assign min_ones   = r_disp.min_ones;
  assign min_tens   = r_disp.min_tens;
  assign running    = (r_state == RUN);
  assign lap_active = r_lap_out;
  assign wrap       = r_wrap_out;

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Directed bench for bcd_stopwatch with a queue-based scoreboard.
// Stimulus pushes expected display states and wrap cycles; monitor compares.
// Keys active-low, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, tick period 4 clk.
module tb_bcd_stopwatch;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_in = 1'b0;
  logic       key_start = 1'b1;
  logic       key_clear = 1'b1;
  logic       key_lap = 1'b1;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic       running, lap_active, wrap;

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    logic [15:0] mmss;
    logic        run;
    logic        lap;
    bit          wq_empty;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    wrap_q[$];

  bcd_stopwatch #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .KEY_ACTIVE_LOW (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tick_in   (tick_in),
    .key_start (key_start),
    .key_clear (key_clear),
    .key_lap   (key_lap),
    .sec_ones  (sec_ones),
    .sec_tens  (sec_tens),
    .min_ones  (min_ones),
    .min_tens  (min_tens),
    .running   (running),
    .lap_active(lap_active),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares popped display expectations and every wrap pulse.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string nm;
      logic [15:0] got;
      e   = exp_q.pop_front();
      nm  = name_q.pop_front();
      got = {min_tens, min_ones, sec_tens, sec_ones};
      n_chk++;
      if (got === e.mmss && running === e.run && lap_active === e.lap &&
          (!e.wq_empty || wrap_q.size() == 0)) begin
        n_pass++;
      end else begin
        $display("FAIL %s: got %h run=%b lap=%b pending_wraps=%0d, want %h run=%b lap=%b",
                 nm, got, running, lap_active, wrap_q.size(), e.mmss, e.run, e.lap);
      end
    end
    if (wrap === 1'b1) begin
      n_chk++;
      if (wrap_q.size() == 0) begin
        $display("FAIL wrap_pulse: wrap high at cycle %0d, want no wrap", cyc);
      end else begin
        int w;
        w = wrap_q.pop_front();
        if (w == cyc) n_pass++;
        else $display("FAIL wrap_pulse: wrap high at cycle %0d, want cycle %0d", cyc, w);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_in = 1'b1;
      cycles(2);
      tick_in = 1'b0;
      cycles(2);
    end
  endtask

  task automatic set_key(input int k, input logic v);
    case (k)
      0:       key_start = v;
      1:       key_clear = v;
      default: key_lap   = v;
    endcase
  endtask

  // k: 0 start, 1 clear, 2 lap. Hold, release, then outlast the lockout.
  task automatic press(input int k);
    set_key(k, 1'b0);
    cycles(3);
    set_key(k, 1'b1);
    cycles(8);
  endtask

  task automatic expect_out(input string nm, input logic [15:0] mmss,
                            input logic run, input logic lap, input bit wq = 1'b0);
    exp_t e;
    cycles(3);
    e.mmss     = mmss;
    e.run      = run;
    e.lap      = lap;
    e.wq_empty = wq;
    exp_q.push_back(e);
    name_q.push_back(nm);
    cycles(1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation still running at cycle %0d, want finish", cyc);
    $fatal(1);
  end

  initial begin
    // 1: reset, start, 75 ticks -> 01:15
    expect_out("reset_state", 16'h0000, 1'b0, 1'b0);
    rst = 1'b0;
    cycles(2);
    press(0);
    expect_out("start_from_idle", 16'h0000, 1'b1, 1'b0);
    do_ticks(75);
    expect_out("count_75", 16'h0115, 1'b1, 1'b0);

    // 2: clear, 3599 ticks -> 59:59, one more -> 00:00 with wrap pulse
    press(1);
    expect_out("clear_to_idle", 16'h0000, 1'b0, 1'b0);
    press(0);
    do_ticks(3599);
    expect_out("count_5959", 16'h5959, 1'b1, 1'b0);
    tick_in = 1'b1;
    wrap_q.push_back(cyc + 4);
    cycles(2);
    tick_in = 1'b0;
    cycles(2);
    expect_out("wrap_to_zero", 16'h0000, 1'b1, 1'b0, 1'b1);

    // 3: pause holds, resume counts
    do_ticks(10);
    expect_out("count_10", 16'h0010, 1'b1, 1'b0);
    press(0);
    expect_out("pause", 16'h0010, 1'b0, 1'b0);
    do_ticks(5);
    expect_out("pause_holds", 16'h0010, 1'b0, 1'b0);
    press(0);
    do_ticks(3);
    expect_out("resume_13", 16'h0013, 1'b1, 1'b0);

    // 4: lap freeze while the count keeps going
    do_ticks(7);
    expect_out("count_20", 16'h0020, 1'b1, 1'b0);
    press(2);
    expect_out("lap_freeze", 16'h0020, 1'b1, 1'b1);
    do_ticks(7);
    expect_out("lap_holds", 16'h0020, 1'b1, 1'b1);
    press(2);
    expect_out("lap_release", 16'h0027, 1'b1, 1'b0);

    // 5: bouncing start gives one transition; clear wins over start+tick
    key_start = 1'b0; cycles(1);
    key_start = 1'b1; cycles(1);
    key_start = 1'b0; cycles(3);
    key_start = 1'b1; cycles(8);
    expect_out("bounce_single", 16'h0027, 1'b0, 1'b0);
    press(0);
    expect_out("bounce_resume", 16'h0027, 1'b1, 1'b0);
    press(2);
    key_clear = 1'b0; key_start = 1'b0; tick_in = 1'b1;
    cycles(2);
    tick_in = 1'b0;
    cycles(1);
    key_clear = 1'b1; key_start = 1'b1;
    cycles(8);
    expect_out("clear_priority", 16'h0000, 1'b0, 1'b0);
    press(2);
    expect_out("lap_in_idle", 16'h0000, 1'b0, 1'b0);
    do_ticks(1);
    expect_out("tick_in_idle", 16'h0000, 1'b0, 1'b0);
    key_start = 1'b0; tick_in = 1'b1;
    cycles(2);
    tick_in = 1'b0;
    cycles(1);
    key_start = 1'b1;
    cycles(8);
    expect_out("idle_start_tick", 16'h0000, 1'b1, 1'b0);
    do_ticks(1);
    expect_out("first_tick", 16'h0001, 1'b1, 1'b0);

    // 6: reset at 12:34 with lap active and start lockout running
    do_ticks(753);
    expect_out("count_1234", 16'h1234, 1'b1, 1'b0);
    press(2);
    expect_out("lap_1234", 16'h1234, 1'b1, 1'b1);
    key_start = 1'b0;
    cycles(4);
    #2;
    rst = 1'b1;
    expect_out("async_reset", 16'h0000, 1'b0, 1'b0);
    key_start = 1'b1;
    cycles(2);
    rst = 1'b0;
    cycles(4);
    press(0);
    expect_out("start_after_reset", 16'h0000, 1'b1, 1'b0, 1'b1);

    cycles(5);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
